// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared constants for the FPU issue controller.
// State, rounding-mode, flag-index and CSR-select encodings.
package fpu_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_ISSUE = 2'd1;
    localparam state_t S_WAIT  = 2'd2;
    localparam state_t S_WB    = 2'd3;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
    localparam logic [2:0] RM_DYN = 3'b111;

    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    localparam logic [1:0] CSR_FFLAGS = 2'b00;
    localparam logic [1:0] CSR_FRM    = 2'b01;
    localparam logic [1:0] CSR_FCSR   = 2'b10;

    function automatic logic rm_reserved(input logic [2:0] rm);
        return rm > RM_RMM;
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Pipeline, FPU-core, writeback and CSR signals of fpu_issue_ctrl.
// master = controller view, slave = surrounding environment view.
interface fpu_issue_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [2:0]  req_rm;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_rd;

    logic        fpu_valid_in;
    logic        fpu_ready_out;
    logic [4:0]  fpu_op;
    logic [2:0]  fpu_rm;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;

    logic        fpu_valid_out;
    logic        fpu_ready_in;
    logic [31:0] fpu_result;
    logic        fpu_IV;
    logic        fpu_DZ;
    logic        fpu_OF;
    logic        fpu_UF;
    logic        fpu_IE;

    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  wb_flags;

    logic        csr_we;
    logic [1:0]  csr_sel;
    logic [7:0]  csr_wdata;
    logic [7:0]  csr_rdata;

    logic        illegal;
    logic        busy;
    logic        timeout;

    modport master (
        input  req_valid, req_op, req_rm, req_a, req_b, req_rd,
        output req_ready,
        output fpu_valid_in, fpu_op, fpu_rm, fpu_a, fpu_b,
        input  fpu_ready_out,
        input  fpu_valid_out, fpu_result,
        input  fpu_IV, fpu_DZ, fpu_OF, fpu_UF, fpu_IE,
        output fpu_ready_in,
        output wb_valid, wb_rd, wb_data, wb_flags,
        input  wb_ready,
        input  csr_we, csr_sel, csr_wdata,
        output csr_rdata,
        output illegal, busy, timeout
    );

    modport slave (
        output req_valid, req_op, req_rm, req_a, req_b, req_rd,
        input  req_ready,
        input  fpu_valid_in, fpu_op, fpu_rm, fpu_a, fpu_b,
        output fpu_ready_out,
        output fpu_valid_out, fpu_result,
        output fpu_IV, fpu_DZ, fpu_OF, fpu_UF, fpu_IE,
        input  fpu_ready_in,
        input  wb_valid, wb_rd, wb_data, wb_flags,
        output wb_ready,
        output csr_we, csr_sel, csr_wdata,
        input  csr_rdata,
        input  illegal, busy, timeout
    );

endinterface

// File: rtl/fpu_issue_ctrl_csr.sv
// fpu_csr: frm/fflags state, write priority, flag accumulation, read mux.
// frm sits in bits [7:5] and fflags in [4:0] in every CSR view.
module fpu_csr
    import fpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_we,
    input  logic [1:0] i_sel,
    input  logic [7:0] i_wdata,
    input  logic       i_acc,
    input  logic [4:0] i_acc_flags,
    output logic [2:0] o_frm,
    output logic [7:0] o_rdata
);

    logic [2:0] r_frm;
    logic [4:0] r_fflags;
    logic       w_wr_frm;
    logic       w_wr_flags;

    assign w_wr_frm   = i_we && (i_sel == CSR_FRM    || i_sel == CSR_FCSR);
    assign w_wr_flags = i_we && (i_sel == CSR_FFLAGS || i_sel == CSR_FCSR);

    // An explicit fflags write overrides same-cycle accumulation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frm    <= '0;
            r_fflags <= '0;
        end else begin
            if (w_wr_frm)
                r_frm <= i_wdata[7:5];
            if (w_wr_flags)
                r_fflags <= i_wdata[4:0];
            else if (i_acc)
                r_fflags <= r_fflags | i_acc_flags;
        end
    end

    always_comb begin
        o_rdata = '0;
        unique case (1'b1)
            (i_sel == CSR_FFLAGS): o_rdata = {3'b000, r_fflags};
            (i_sel == CSR_FRM):    o_rdata = {r_frm, 5'b00000};
            (i_sel == CSR_FCSR):   o_rdata = {r_frm, r_fflags};
            default:               o_rdata = '0;
        endcase
    end

    assign o_frm = r_frm;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-outstanding FPU issue controller with dynamic-rm resolution.
// Optional watchdog built when FPU_WATCHDOG_EN is defined.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,
    fpu_issue_ctrl_if.master bus
);

    state_t      r_state;
    logic [4:0]  r_op;
    logic [2:0]  r_rm;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_rd;
    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_flags;
    logic        r_illegal;
    logic        r_timeout;

    logic [2:0]  w_frm;
    logic [2:0]  w_rm;
    logic        w_rsv;
    logic        w_accept;
    logic        w_start;
    logic        w_wb_done;
    logic        w_wd_fire;
    logic        w_acc;
    logic [4:0]  w_acc_flags;

    assign w_rm      = (bus.req_rm == RM_DYN) ? w_frm : bus.req_rm;
    assign w_rsv     = rm_reserved(w_rm);
    assign w_accept  = (r_state == S_IDLE) && bus.req_valid;
    assign w_start   = w_accept && !w_rsv;
    assign w_wb_done = (r_state == S_WB) && bus.wb_ready;

`ifdef FPU_WATCHDOG_EN
    localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                          $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [WD_W-1:0] r_wd_cnt;
    logic            w_wd_run;

    assign w_wd_run  = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign w_wd_fire = w_wd_run && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_wd_cnt <= '0;
        else if (w_start)
            r_wd_cnt <= '0;
        else if (w_wd_run)
            r_wd_cnt <= r_wd_cnt + 1'b1;
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_wd_fire        = 1'b0;
`endif

    // A watchdog abort reports itself as an invalid operation
    assign w_acc       = w_wb_done || w_wd_fire;
    assign w_acc_flags = w_wd_fire ? 5'b10000 : r_wb_flags;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_rm       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_rd       <= '0;
            r_wb_data  <= '0;
            r_wb_flags <= '0;
            r_illegal  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_illegal <= w_accept && w_rsv;
            r_timeout <= w_wd_fire;
            if (w_wd_fire) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: if (w_start) begin
                        r_op    <= bus.req_op;
                        r_rm    <= w_rm;
                        r_a     <= bus.req_a;
                        r_b     <= bus.req_b;
                        r_rd    <= bus.req_rd;
                        r_state <= S_ISSUE;
                    end
                    S_ISSUE: if (bus.fpu_ready_out)
                        r_state <= S_WAIT;
                    S_WAIT: if (bus.fpu_valid_out) begin
                        r_wb_data  <= bus.fpu_result;
                        r_wb_flags <= {bus.fpu_IV, bus.fpu_DZ,
                                       bus.fpu_OF, bus.fpu_UF,
                                       bus.fpu_IE};
                        r_state    <= S_WB;
                    end
                    S_WB: if (bus.wb_ready)
                        r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    fpu_csr u_csr (
        .clk         (clk),
        .reset       (reset),
        .i_we        (bus.csr_we),
        .i_sel       (bus.csr_sel),
        .i_wdata     (bus.csr_wdata),
        .i_acc       (w_acc),
        .i_acc_flags (w_acc_flags),
        .o_frm       (w_frm),
        .o_rdata     (bus.csr_rdata)
    );

    assign bus.req_ready    = (r_state == S_IDLE);
    assign bus.fpu_valid_in = (r_state == S_ISSUE);
    assign bus.fpu_ready_in = (r_state == S_WAIT);
    assign bus.wb_valid     = (r_state == S_WB);
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.fpu_op       = r_op;
    assign bus.fpu_rm       = r_rm;
    assign bus.fpu_a        = r_a;
    assign bus.fpu_b        = r_b;
    assign bus.wb_rd        = r_rd;
    assign bus.wb_data      = r_wb_data;
    assign bus.wb_flags     = r_wb_flags;
    assign bus.illegal      = r_illegal;
    assign bus.timeout      = r_timeout;

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Initiator-side controller that sits between the integer pipeline and the FPU core. It accepts one FP request at a time, resolves dynamic rounding, and drives the core's valid/ready request channel. It collects the result and exception flags, presents them on a writeback channel, and owns the sticky `fflags`/`frm` CSR state. At most one operation is outstanding.

## Interface
- `TIMEOUT_CYCLES`, 255: watchdog limit in cycles; used only with `FPU_WATCHDOG_EN`.
- `clk` in 1: clock
- `reset` in 1: asynchronous, active-high reset
- `req_valid` in 1, `req_ready` out 1: pipeline request handshake
- `req_op` in 5, `req_rm` in 3, `req_a` in 32, `req_b` in 32, `req_rd` in 5: operation, instruction rm field, operands, destination tag
- `fpu_valid_in` out 1, `fpu_ready_out` in 1: request to FPU core
- `fpu_op` out 5, `fpu_rm` out 3, `fpu_a` out 32, `fpu_b` out 32: latched request fields
- `fpu_valid_out` in 1, `fpu_ready_in` out 1: response from FPU core
- `fpu_result` in 32, `fpu_IV`/`fpu_DZ`/`fpu_OF`/`fpu_UF`/`fpu_IE` in 1 each: core result and flags
- `wb_valid` out 1, `wb_ready` in 1: writeback handshake
- `wb_rd` out 5, `wb_data` out 32, `wb_flags` out 5: writeback payload; `wb_flags` = {NV,DZ,OF,UF,NX}
- `csr_we` in 1, `csr_sel` in 2, `csr_wdata` in 8, `csr_rdata` out 8: CSR access
  - `csr_sel`: 00 fflags, 01 frm, 10 fcsr
  - `csr_rdata` = {frm,fflags}, masked per `csr_sel`, combinational
- `illegal` out 1: one-cycle pulse when the resolved rm is reserved
- `busy` out 1: high in any state other than IDLE
- `timeout` out 1: one-cycle watchdog pulse; constant 0 without the macro

## Operation
- FSM states: IDLE, ISSUE, WAIT, WB.
- IDLE
  - `req_ready`=1.
  - On `req_valid`, resolve rm: `req_rm`==111 selects `frm`, otherwise `req_rm` is used.
  - Resolved rm in {101,110,111}: request is consumed, `illegal` pulses the next cycle, and the FSM stays in IDLE.
  - Otherwise op, rm, a, b and rd are latched and the FSM moves to ISSUE.
- ISSUE
  - `fpu_valid_in`=1.
  - On `fpu_ready_out`=1, move to WAIT.
- WAIT
  - `fpu_ready_in`=1.
  - On `fpu_valid_out`=1, latch `fpu_result` into `wb_data` and {IV,DZ,OF,UF,IE} into `wb_flags`, then move to WB.
- WB
  - `wb_valid`=1.
  - On `wb_ready`=1, `fflags` <= `fflags` | `wb_flags`, then move to IDLE.
- Handshake outputs are asserted only in their state.
- `fpu_*` request fields stay stable from ISSUE until the handshake completes.
- `wb_*` payload stays stable while `wb_valid`=1.
- CSR writes
  - Writes land at the clock edge.
  - fcsr writes `csr_wdata[7:5]` to `frm` and `[4:0]` to `fflags`.
  - An `frm` write never affects an already-latched op.
- CSR write to `fflags` coinciding with WB accumulation: the CSR write value wins and the accumulation is dropped.
- Reserved `frm` values (101–111) are storable. They cause `illegal` only when an op selects dynamic rm.

## Timing
- Reset values: state IDLE, `frm`=000, `fflags`=0, all latches 0.
  - Outputs under reset: `req_ready`=1, everything else 0.
- Reset mid-operation: return to IDLE and discard the in-flight result. No flags are accumulated.
- Best-case latency, from request accepted at edge 0:
  - `fpu_valid_in` high in cycle 1.
  - If `fpu_ready_out`=1 in cycle 1 and `fpu_valid_out`=1 in cycle 2, `wb_valid` is high in cycle 3.
- Throughput: one op per 4 cycles minimum. `req_ready` is 0 from ISSUE through WB.
- The illegal path takes 1 cycle. `illegal` pulses in the cycle after acceptance, and `req_ready` stays 1.

## Configuration
- Macro `FPU_WATCHDOG_EN`.
- Defined:
  - An 8+ bit counter clears on entering ISSUE and increments in ISSUE/WAIT.
  - On reaching `TIMEOUT_CYCLES`: `timeout` pulses for 1 cycle, the FSM returns to IDLE, no writeback occurs, and `fflags` gets NV set.
- Undefined: no counter is built, `timeout`=0, and the FSM waits indefinitely.

## Structure
- Package `fpu_pkg`:
  - state enum
  - rm encodings RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100, DYN=111
  - fflags bit indices NV=4, DZ=3, OF=2, UF=1, NX=0
  - `csr_sel` encodings
- Sub-module `fpu_csr`: holds `frm`/`fflags`, write priority, flag accumulation and read mux.

## Test plan
- `frm`=000, request op with `req_rm`=001 and `fpu_ready_out`/`fpu_valid_out` immediate → `fpu_rm`=001, `wb_valid` in cycle 3, `wb_data`=`fpu_result`.
- `frm` written to 010, request with `req_rm`=111 → `fpu_rm`=010. A CSR write of `frm`=011 during WAIT leaves `fpu_rm`=010.
- `req_rm`=101 → `illegal` pulses 1 cycle, no `fpu_valid_in`, `req_ready` stays 1.
- Two ops returning flags 10000 then 00001, with `wb_ready` held low 3 cycles on the first → `wb_*` stable while stalled, `fflags`=10001 afterwards.
- `csr_we` fflags=00000 in the same cycle as the WB handshake with `wb_flags`=00100 → `fflags`=00000.
- With `FPU_WATCHDOG_EN` and `TIMEOUT_CYCLES`=8, `fpu_ready_out` held 0 → `timeout` pulses, FSM returns to IDLE, `fflags`[4]=1, no `wb_valid`. Assert reset mid-WAIT in a separate run → all outputs at reset values.
